// File: rtl/mux_full_adder.sv
// Ripple-carry adder whose bit cells are built purely from 2:1/4:1 multiplexers.
// Latency: 1 cycle from in_valid to out_valid. No backpressure: one result per cycle, always accepted.

module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// 4:1 mux as a tree of three 2:1 muxes; d[k] is selected when sel == k.
module mux4 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);
    logic lo;
    logic hi;

    mux2 u_lo  (.d0(d[0]), .d1(d[1]), .sel(sel[0]), .y(lo));
    mux2 u_hi  (.d0(d[2]), .d1(d[3]), .sel(sel[0]), .y(hi));
    mux2 u_top (.d0(lo),   .d1(hi),   .sel(sel[1]), .y(y));
endmodule

module mux_full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             C,
    output logic             out_valid
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_w;

    assign carry[0] = Cin;

    // Select is {A[i],B[i]}: the operand pair picks which function of the incoming carry to pass.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic ci;
        logic ci_n;

        assign ci   = carry[i];
        assign ci_n = ~carry[i];

        mux4 u_sum (
            .d   ({ci, ci_n, ci_n, ci}),
            .sel ({A[i], B[i]}),
            .y   (sum_w[i])
        );

        mux4 u_carry (
            .d   ({1'b1, ci, ci, 1'b0}),
            .sel ({A[i], B[i]}),
            .y   (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= '0;
            C         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum <= sum_w;
                C   <= carry[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_mux_full_adder.sv
// Directed and random checks of mux_full_adder at widths 1, 4 and 8.
module tb_mux_full_adder;
    logic clk = 1'b0;
    logic rst;

    logic       a1, b1, ci1, iv1, s1, c1, ov1;
    logic [3:0] a4, b4, s4;
    logic       ci4, iv4, c4, ov4;
    logic [7:0] a8, b8, s8;
    logic       ci8, iv8, c8, ov8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(ci1), .in_valid(iv1),
        .Sum(s1), .C(c1), .out_valid(ov1)
    );
    mux_full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(ci4), .in_valid(iv4),
        .Sum(s4), .C(c4), .out_valid(ov4)
    );
    mux_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(ci8), .in_valid(iv8),
        .Sum(s8), .C(c8), .out_valid(ov8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] s_tab;
        logic [7:0] c_tab;
        logic [8:0] exp9;

        s_tab = 8'b1001_0110;
        c_tab = 8'b1110_1000;

        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; iv1 = 1'b1;
        a4 = 4'h1; b4 = 4'h1; ci4 = 1'b1; iv4 = 1'b1;
        a8 = 8'h1; b8 = 8'h1; ci8 = 1'b1; iv8 = 1'b1;

        for (int k = 0; k < 2; k++) begin
            step();
            check("rst_s1", s1, 0);   check("rst_c1", c1, 0);   check("rst_ov1", ov1, 0);
            check("rst_s4", s4, 0);   check("rst_c4", c4, 0);   check("rst_ov4", ov4, 0);
            check("rst_s8", s8, 0);   check("rst_c8", c8, 0);   check("rst_ov8", ov8, 0);
        end
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; ci1 = v[0]; iv1 = 1'b1;
            step();
            check($sformatf("w1_s_%0d", v), s1, s_tab[v]);
            check($sformatf("w1_c_%0d", v), c1, c_tab[v]);
            check($sformatf("w1_ov_%0d", v), ov1, 1);
        end
        iv1 = 1'b0;

        a4 = 4'hF; b4 = 4'h1; ci4 = 1'b1; iv4 = 1'b1;
        step();
        check("wrap_s", s4, 4'h1); check("wrap_c", c4, 1); check("wrap_ov", ov4, 1);
        a4 = 4'h5; b4 = 4'hA; ci4 = 1'b0;
        step();
        check("5pA_s", s4, 4'hF); check("5pA_c", c4, 0); check("5pA_ov", ov4, 1);

        a4 = 4'h3; b4 = 4'h4; ci4 = 1'b0;
        step();
        check("hold_load_s", s4, 4'h7);
        a4 = 4'h9; b4 = 4'h9; iv4 = 1'b0;
        step();
        check("hold_s", s4, 4'h7); check("hold_c", c4, 0); check("hold_ov", ov4, 0);

        a4 = 4'h2; b4 = 4'h2; ci4 = 1'b0; iv4 = 1'b1;
        step();
        check("mid_pre_s", s4, 4'h4); check("mid_pre_ov", ov4, 1);
        a4 = 4'h6; b4 = 4'h6; rst = 1'b1;
        step();
        check("mid_rst_s", s4, 0); check("mid_rst_c", c4, 0); check("mid_rst_ov", ov4, 0);
        rst = 1'b0; iv4 = 1'b0;
        step();
        check("post_rst_ov", ov4, 0);
        a4 = 4'h6; b4 = 4'h6; ci4 = 1'b1; iv4 = 1'b1;
        step();
        check("post_rst_s", s4, 4'hD); check("post_rst_c", c4, 0); check("post_rst_ov", ov4, 1);
        iv4 = 1'b0;

        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; iv8 = 1'b1;
        step();
        check("ones_s", s8, 8'hFF); check("ones_c", c8, 1);
        a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
        step();
        check("zero_s", s8, 8'h00); check("zero_c", c8, 0);

        for (int n = 0; n < 1000; n++) begin
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            ci8 = 1'($urandom_range(0, 1));
            exp9 = {1'b0, a8} + {1'b0, b8} + {8'd0, ci8};
            step();
            check("rand_sum", {c8, s8}, exp9);
            check("rand_ov", ov8, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
